pte_ad_update_unit: RTL and testbench
=====================================

Name: pte_ad_update_unit

Overview:
- Page-table-walker back-end. Sets the Accessed (A) and Dirty (D) bits in a leaf PTE and writes the updated PTE back to memory through a request/response port.
- Parametrised over PTE width, so one block serves Sv32 (32-bit PTE) and Sv39/Sv48 (64-bit PTE).
- Accepts one update job at a time from the PTW and returns a completion record.
- Sits between the PTW walk FSM and the data-side memory arbiter.

Parameters:
- PTE_W, 32, PTE width in bits; legal values are 32 and 64.
- PADDR_W, 34, physical address width of the PTE location.
- BIT_A, 6, bit index of A in the PTE.
- BIT_D, 7, bit index of D in the PTE.
- MAX_RETRY, 3, maximum CAS retries. Used only when PTE_AD_CAS_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  job valid
- req_ready_o  out  1  unit can accept a job
- req_addr_i  in  PADDR_W  physical address of the PTE
- req_pte_i  in  PTE_W  PTE value as read by the walker
- req_set_a_i  in  1  access requires A=1
- req_set_d_i  in  1  store access; requires D=1 (implies A)
- mem_req_valid_o  out  1  writeback request valid
- mem_req_ready_i  in  1  memory accepts the request
- mem_req_addr_o  out  PADDR_W  writeback address
- mem_req_data_o  out  PTE_W  updated PTE
- mem_req_cmp_o  out  PTE_W  expected old PTE (CAS); driven 0 without the feature
- mem_rsp_valid_i  in  1  memory response valid (always accepted)
- mem_rsp_err_i  in  1  bus error
- mem_rsp_data_i  in  PTE_W  memory value before the write (CAS); ignored without the feature
- done_valid_o  out  1  completion valid
- done_ready_i  in  1  PTW consumes the completion
- done_pte_o  out  PTE_W  final PTE value
- done_wrote_o  out  1  a writeback occurred
- done_err_o  out  1  fault (V=0, bus error, or retries exhausted)

Behaviour:
- Reset values: state IDLE; req_ready_o=1; all other outputs 0. Reset asserted mid-job abandons the job; no further mem_req_valid_o is issued and any late response is ignored.
- States are IDLE, WRITE, WAIT_RSP, DONE.
- IDLE: req_ready_o=1. On req_valid_i && req_ready_o, the unit registers addr/pte/flags and computes:
  - need_a = (set_a|set_d) & ~pte[BIT_A]
  - need_d = set_d & ~pte[BIT_D]
  - new_pte = pte with A forced to 1 if need_a and D forced to 1 if need_d
- IDLE transitions on acceptance:
  - If pte[0] (V)=0 -> DONE with err=1, wrote=0, done_pte=original.
  - Else if need_a|need_d = 0 -> DONE with wrote=0, done_pte=original.
  - Else -> WRITE.
  - Completion without a write: done_valid_o asserts exactly 1 cycle after acceptance.
- WRITE: mem_req_valid_o=1 with addr/data/cmp held stable until mem_req_ready_i. On handshake -> WAIT_RSP. The request is asserted the cycle after acceptance.
- WAIT_RSP: on mem_rsp_valid_i:
  - If err -> DONE with err=1, wrote=0.
  - Else -> DONE with wrote=1, done_pte=new_pte.
  - A response arriving in the same cycle as the request handshake cannot occur; the arbiter guarantees at least 1 cycle of latency.
- DONE: done_valid_o=1 with all done fields held stable until done_ready_i, then -> IDLE. req_ready_o=0 in every state except IDLE, so there is no back-to-back accept in the DONE->IDLE cycle.
- Bits other than A and D are never modified. For PTE_W=64, the upper bits pass through unchanged.
- A stray mem_rsp_valid_i outside WAIT_RSP is ignored.

Optional Feature:
- Macro: PTE_AD_CAS_EN.
- With the macro defined:
  - The writeback is an atomic compare-and-swap: mem_req_cmp_o = PTE value the update was computed from.
  - In WAIT_RSP without error, if mem_rsp_data_i == cmp, the job completes as a success.
  - Otherwise the unit recomputes from mem_rsp_data_i: new V=0 -> DONE err; nothing needed -> DONE wrote=0, done_pte=mem value; else increment the retry counter and return to WRITE.
  - Retry counter reaches MAX_RETRY -> DONE with err=1.
  - The counter is cleared on each new job.
- Without the macro: plain store, mem_req_cmp_o=0, mem_rsp_data_i unused, no retry counter.

Test Plan:
- Sv32, pte=0x0000_0001, set_a=1, set_d=0 -> mem write data 0x0000_0041, done_wrote=1, done_pte=0x41, done_err=0.
- pte=0x0000_00C7, set_d=1 -> no mem request; done_valid 1 cycle after accept; wrote=0, pte=0xC7.
- pte=0x0000_0000, set_a=1 -> no mem request; done_err=1.
- mem_req_ready held 0 for 5 cycles, then rsp_err=1 -> request fields stable all 5 cycles; done_err=1, wrote=0.
- PTE_W=64, pte=0xFFC0_0000_0000_0003, set_d=1 -> data 0xFFC0_0000_0000_00C3. Additionally, rst_n dropped while in WAIT_RSP -> all outputs 0 and a later response is ignored.
- CAS (PTE_AD_CAS_EN), MAX_RETRY=3, pte=0x01, set_a=1, responses 0x11, 0x11: first attempt cmp=0x01 mismatches; retry with cmp=0x11, data=0x51 matches -> done_pte=0x51, wrote=1. With every response mismatching, the job ends with err=1 after 3 retries.

Source files
------------

// File: rtl/pte_ad_update_unit.sv
// PTE Accessed/Dirty update engine: sets A/D in a leaf PTE and writes it back to memory.
// Define PTE_AD_CAS_EN to make the writeback a compare-and-swap with bounded retry.
module pte_ad_update_unit #(
   parameter int PTE_W     = 32,
   parameter int PADDR_W   = 34,
   parameter int BIT_A     = 6,
   parameter int BIT_D     = 7,
   parameter int MAX_RETRY = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [PADDR_W-1:0] req_addr_i,
   input  logic [PTE_W-1:0]   req_pte_i,
   input  logic               req_set_a_i,
   input  logic               req_set_d_i,
   output logic               mem_req_valid_o,
   input  logic               mem_req_ready_i,
   output logic [PADDR_W-1:0] mem_req_addr_o,
   output logic [PTE_W-1:0]   mem_req_data_o,
   output logic [PTE_W-1:0]   mem_req_cmp_o,
   input  logic               mem_rsp_valid_i,
   input  logic               mem_rsp_err_i,
   input  logic [PTE_W-1:0]   mem_rsp_data_i,
   output logic               done_valid_o,
   input  logic               done_ready_i,
   output logic [PTE_W-1:0]   done_pte_o,
   output logic               done_wrote_o,
   output logic               done_err_o
);

   typedef enum logic [1:0] {IDLE, WRITE, WAIT_RSP, DONE} state_t;

   state_t             state, next_state;
   logic [PADDR_W-1:0] addr_q;
   logic [PTE_W-1:0]   base_q;
   logic [PTE_W-1:0]   new_q;
   logic [PTE_W-1:0]   done_pte_q;
   logic               done_wrote_q;
   logic               done_err_q;
   logic [PTE_W-1:0]   acc_new;

   // Returns the PTE with A/D forced as the access demands; equal to the input when nothing is needed.
   function automatic logic [PTE_W-1:0] ad_update(input logic [PTE_W-1:0] pte,
                                                   input logic set_a, input logic set_d);
      logic [PTE_W-1:0] result;
      result = pte;
      if ((set_a | set_d) & ~pte[BIT_A]) result[BIT_A] = 1'b1;
      if (set_d & ~pte[BIT_D]) result[BIT_D] = 1'b1;
      return result;
   endfunction

   assign acc_new = ad_update(req_pte_i, req_set_a_i, req_set_d_i);

`ifdef PTE_AD_CAS_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0]    retry_q;
   logic             set_a_q, set_d_q;
   logic [PTE_W-1:0] rsp_new;
   logic             cas_retry;

   // A mismatching CAS retries only while the fresh memory value is valid, still needs work and budget remains.
   assign rsp_new   = ad_update(mem_rsp_data_i, set_a_q, set_d_q);
   assign cas_retry = !mem_rsp_err_i && (mem_rsp_data_i != base_q) && mem_rsp_data_i[0] &&
                      (rsp_new != mem_rsp_data_i) && (retry_q != RW'(MAX_RETRY));
`else
   localparam int unused_max_retry = MAX_RETRY;
   logic unused_rsp_data;
   assign unused_rsp_data = ^mem_rsp_data_i;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req_valid_i)
            next_state = (!req_pte_i[0] || acc_new == req_pte_i) ? DONE : WRITE;
         WRITE: if (mem_req_ready_i) next_state = WAIT_RSP;
         WAIT_RSP: if (mem_rsp_valid_i) begin
            next_state = DONE;
`ifdef PTE_AD_CAS_EN
            if (cas_retry) next_state = WRITE;
`endif
         end
         DONE: if (done_ready_i) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Job datapath: captured on acceptance, completion fields resolved when the response lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         base_q       <= '0;
         new_q        <= '0;
         done_pte_q   <= '0;
         done_wrote_q <= 1'b0;
         done_err_q   <= 1'b0;
`ifdef PTE_AD_CAS_EN
         retry_q      <= '0;
         set_a_q      <= 1'b0;
         set_d_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid_i) begin
               addr_q       <= req_addr_i;
               base_q       <= req_pte_i;
               new_q        <= acc_new;
               done_pte_q   <= req_pte_i;
               done_wrote_q <= 1'b0;
               done_err_q   <= ~req_pte_i[0];
`ifdef PTE_AD_CAS_EN
               retry_q      <= '0;
               set_a_q      <= req_set_a_i;
               set_d_q      <= req_set_d_i;
`endif
            end
            WAIT_RSP: if (mem_rsp_valid_i) begin
               if (mem_rsp_err_i) begin
                  done_err_q <= 1'b1;
               end
`ifdef PTE_AD_CAS_EN
               else if (mem_rsp_data_i != base_q) begin
                  if (cas_retry) begin
                     retry_q <= retry_q + 1'b1;
                     base_q  <= mem_rsp_data_i;
                     new_q   <= rsp_new;
                  end else if (!mem_rsp_data_i[0]) begin
                     done_err_q <= 1'b1;
                     done_pte_q <= mem_rsp_data_i;
                  end else if (rsp_new == mem_rsp_data_i) begin
                     done_pte_q <= mem_rsp_data_i;
                  end else begin
                     done_err_q <= 1'b1;
                  end
               end
`endif
               else begin
                  done_wrote_q <= 1'b1;
                  done_pte_q   <= new_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready_o     = 1'b0;
      mem_req_valid_o = 1'b0;
      mem_req_addr_o  = '0;
      mem_req_data_o  = '0;
      mem_req_cmp_o   = '0;
      done_valid_o    = 1'b0;
      done_pte_o      = '0;
      done_wrote_o    = 1'b0;
      done_err_o      = 1'b0;
      case (state)
         IDLE: req_ready_o = 1'b1;
         WRITE: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = addr_q;
            mem_req_data_o  = new_q;
`ifdef PTE_AD_CAS_EN
            mem_req_cmp_o   = base_q;
`endif
         end
         DONE: begin
            done_valid_o = 1'b1;
            done_pte_o   = done_pte_q;
            done_wrote_o = done_wrote_q;
            done_err_o   = done_err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pte_ad_update_unit.sv
// Directed bench for pte_ad_update_unit: Sv32 and 64-bit instances share one stimulus stream.
module tb_pte_ad_update_unit;

   typedef struct {
      logic [63:0] pte;
      logic        sa, sd, err;
      int          delay;
      logic        wr;
      logic [63:0] data, done_pte;
      logic        wrote, derr;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 0, set_a = 0, set_d = 0, mem_req_ready = 0;
   logic        mem_rsp_valid = 0, mem_rsp_err = 0, done_ready = 0;
   logic [33:0] req_addr = '0;
   logic [63:0] req_pte = '0, mem_rsp_data = '0;

   logic        req_ready_64, mem_req_valid_64, done_valid_64, done_wrote_64, done_err_64;
   logic [33:0] mem_req_addr_64;
   logic [63:0] mem_req_data_64, mem_req_cmp_64, done_pte_64;
   logic        req_ready_32, mem_req_valid_32, done_valid_32, done_wrote_32, done_err_32;
   logic [33:0] mem_req_addr_32;
   logic [31:0] mem_req_data_32, mem_req_cmp_32, done_pte_32;

   int   n_vec = 0, n_fail = 0;
   vec_t vecs[12];

   pte_ad_update_unit #(.PTE_W(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_64),
      .req_addr_i(req_addr), .req_pte_i(req_pte), .req_set_a_i(set_a), .req_set_d_i(set_d),
      .mem_req_valid_o(mem_req_valid_64), .mem_req_ready_i(mem_req_ready),
      .mem_req_addr_o(mem_req_addr_64), .mem_req_data_o(mem_req_data_64), .mem_req_cmp_o(mem_req_cmp_64),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_err_i(mem_rsp_err), .mem_rsp_data_i(mem_rsp_data),
      .done_valid_o(done_valid_64), .done_ready_i(done_ready), .done_pte_o(done_pte_64),
      .done_wrote_o(done_wrote_64), .done_err_o(done_err_64));

   pte_ad_update_unit #(.PTE_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_32),
      .req_addr_i(req_addr), .req_pte_i(req_pte[31:0]), .req_set_a_i(set_a), .req_set_d_i(set_d),
      .mem_req_valid_o(mem_req_valid_32), .mem_req_ready_i(mem_req_ready),
      .mem_req_addr_o(mem_req_addr_32), .mem_req_data_o(mem_req_data_32), .mem_req_cmp_o(mem_req_cmp_32),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_err_i(mem_rsp_err), .mem_rsp_data_i(mem_rsp_data[31:0]),
      .done_valid_o(done_valid_32), .done_ready_i(done_ready), .done_pte_o(done_pte_32),
      .done_wrote_o(done_wrote_32), .done_err_o(done_err_32));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkHandshake(input logic rdy, input logic memv, input logic dv);
      checkOutput("handshake", 64'({req_ready_64, req_ready_32, mem_req_valid_64, mem_req_valid_32,
                                    done_valid_64, done_valid_32}),
                  64'({rdy, rdy, memv, memv, dv, dv}));
   endtask

   task automatic checkMemReq(input logic [33:0] addr, input logic [63:0] data, input logic [63:0] cmp);
      checkOutput("mem_addr64", 64'(mem_req_addr_64), 64'(addr));
      checkOutput("mem_addr32", 64'(mem_req_addr_32), 64'(addr));
      checkOutput("mem_data64", mem_req_data_64, data);
      checkOutput("mem_data32", 64'(mem_req_data_32), 64'(data[31:0]));
      checkOutput("mem_cmp64", mem_req_cmp_64, cmp);
      checkOutput("mem_cmp32", 64'(mem_req_cmp_32), 64'(cmp[31:0]));
   endtask

   task automatic checkDone(input logic [63:0] pte, input logic wrote, input logic err);
      checkOutput("done_pte64", done_pte_64, pte);
      checkOutput("done_pte32", 64'(done_pte_32), 64'(pte[31:0]));
      checkOutput("done_flags", 64'({done_wrote_64, done_wrote_32, done_err_64, done_err_32}),
                  64'({wrote, wrote, err, err}));
   endtask

   // Called at a negedge in IDLE; returns at the negedge after acceptance.
   task automatic startJob(input logic [33:0] addr, input logic [63:0] pte, input logic a, input logic d);
      checkHandshake(1'b1, 1'b0, 1'b0);
      req_valid = 1'b1; req_addr = addr; req_pte = pte; set_a = a; set_d = d;
      @(negedge clk);
      req_valid = 1'b0; set_a = 1'b0; set_d = 1'b0;
   endtask

   // Holds off the memory for 'delay' cycles, then answers one cycle after the handshake.
   task automatic serveWrite(input logic [33:0] addr, input logic [63:0] data, input logic [63:0] cmp,
                             input int delay, input logic err, input logic [63:0] rsp);
      for (int k = 0; k <= delay; k++) begin
         checkHandshake(1'b0, 1'b1, 1'b0);
         checkMemReq(addr, data, cmp);
         if (k == delay) mem_req_ready = 1'b1;
         @(negedge clk);
      end
      mem_req_ready = 1'b0;
      checkHandshake(1'b0, 1'b0, 1'b0);
      mem_rsp_valid = 1'b1; mem_rsp_err = err; mem_rsp_data = rsp;
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
   endtask

   task automatic finishDone(input logic [63:0] pte, input logic wrote, input logic err);
      checkHandshake(1'b0, 1'b0, 1'b1);
      checkDone(pte, wrote, err);
      @(negedge clk);
      checkHandshake(1'b0, 1'b0, 1'b1);
      checkOutput("done_pte64_held", done_pte_64, pte);
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      checkHandshake(1'b1, 1'b0, 1'b0);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [33:0] addr;
      logic [63:0] cmp, rsp;
      addr = 34'h2_0000_1000 + 34'(idx * 8);
`ifdef PTE_AD_CAS_EN
      cmp = v.pte; rsp = v.pte;
`else
      cmp = '0; rsp = 64'hDEAD_BEEF_0BAD_F00D;
`endif
      startJob(addr, v.pte, v.sa, v.sd);
      if (v.wr) serveWrite(addr, v.data, cmp, v.delay, v.err, rsp);
      else      checkHandshake(1'b0, 1'b0, 1'b1);
      finishDone(v.done_pte, v.wrote, v.derr);
   endtask

   initial begin
      vecs[0]  = '{64'h1, 1, 0, 0, 0, 1, 64'h41, 64'h41, 1, 0};
      vecs[1]  = '{64'hC7, 0, 1, 0, 0, 0, 64'h0, 64'hC7, 0, 0};
      vecs[2]  = '{64'h0, 1, 0, 0, 0, 0, 64'h0, 64'h0, 0, 1};
      vecs[3]  = '{64'h1, 0, 1, 1, 5, 1, 64'hC1, 64'h1, 0, 1};
      vecs[4]  = '{64'hFFC0_0000_0000_0003, 0, 1, 0, 0, 1, 64'hFFC0_0000_0000_00C3,
                   64'hFFC0_0000_0000_00C3, 1, 0};
      vecs[5]  = '{64'h41, 1, 0, 0, 0, 0, 64'h0, 64'h41, 0, 0};
      vecs[6]  = '{64'h81, 0, 1, 0, 2, 1, 64'hC1, 64'hC1, 1, 0};
      vecs[7]  = '{64'h3FF, 0, 0, 0, 0, 0, 64'h0, 64'h3FF, 0, 0};
      vecs[8]  = '{64'hABCD_1234_5678_9A01, 1, 0, 0, 1, 1, 64'hABCD_1234_5678_9A41,
                   64'hABCD_1234_5678_9A41, 1, 0};
      vecs[9]  = '{64'h0, 0, 1, 0, 0, 0, 64'h0, 64'h0, 0, 1};
      vecs[10] = '{64'h80, 1, 0, 0, 0, 0, 64'h0, 64'h80, 0, 1};
      vecs[11] = '{64'hFFFF_FFFF_FFFF_FF3F, 0, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF, 1, 0};

      repeat (2) @(negedge clk);
      checkHandshake(1'b1, 1'b0, 1'b0);
      checkMemReq('0, '0, '0);
      checkDone('0, 1'b0, 1'b0);
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      checkHandshake(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

      // Reset while waiting for the response: job abandoned, late response ignored.
      startJob(34'h1_2345_6780, 64'hFFC0_0000_0000_0003, 1'b0, 1'b1);
      checkHandshake(1'b0, 1'b1, 1'b0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      checkHandshake(1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkHandshake(1'b1, 1'b0, 1'b0);
      checkMemReq('0, '0, '0);
      checkDone('0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkHandshake(1'b1, 1'b0, 1'b0);
      applyStimulus(vecs[0], 0);

`ifdef PTE_AD_CAS_EN
      startJob(34'h100, 64'h1, 1'b1, 1'b0);
      serveWrite(34'h100, 64'h41, 64'h01, 0, 1'b0, 64'h11);
      serveWrite(34'h100, 64'h51, 64'h11, 0, 1'b0, 64'h11);
      finishDone(64'h51, 1'b1, 1'b0);
      startJob(34'h100, 64'h1, 1'b1, 1'b0);
      serveWrite(34'h100, 64'h41, 64'h01, 0, 1'b0, 64'h03);
      serveWrite(34'h100, 64'h43, 64'h03, 0, 1'b0, 64'h05);
      serveWrite(34'h100, 64'h45, 64'h05, 0, 1'b0, 64'h09);
      serveWrite(34'h100, 64'h49, 64'h09, 0, 1'b0, 64'h11);
      finishDone(64'h1, 1'b0, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
